// File: rtl/hazard_scoreboard.sv
// Per-register pending-write counters between ID and WB; stalls decode on RAW hazards or counter saturation.
// Optional macro SCOREBOARD_WB_BYPASS_EN: write-before-read regfile, hazard clears in the WB cycle itself.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_id_valid,
  input  logic [4:0] i_rs1_addr,
  input  logic [4:0] i_rs2_addr,
  input  logic       i_rs1_used,
  input  logic       i_rs2_used,
  input  logic [4:0] i_rd_addr,
  input  logic       i_rd_wren,
  input  logic       i_kill_valid,
  input  logic [4:0] i_kill_rd,
  input  logic       i_wb_wren,
  input  logic [4:0] i_wb_rd_addr,
  output logic       o_stall,
  output logic       o_rs1_hazard,
  output logic       o_rs2_hazard,
  output logic       o_busy_any,
  output logic       o_err
);

  localparam logic [CNT_W-1:0]        CNT_MAX = '1;
  localparam logic signed [CNT_W+1:0] ONE_S   = 1;
  localparam logic signed [CNT_W+1:0] MAX_S   = {2'b00, CNT_MAX};

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic             err_q, err_d;

  logic [NUM_REGS-1:0] pend;
  logic haz1, haz2, sat, stall, busy;
  logic inc, dec_wb, dec_kill;
  logic signed [CNT_W+1:0] net;

  assign dec_wb   = i_wb_wren & (i_wb_rd_addr != 5'd0);
  assign dec_kill = i_kill_valid & (i_kill_rd != 5'd0);

  always_comb begin
    pend = '0;
    busy = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
`ifdef SCOREBOARD_WB_BYPASS_EN
      // Write-before-read: the last outstanding write lands this cycle, so the read sees it.
      pend[r] = (cnt_q[r] != '0) &
                ~(dec_wb & (i_wb_rd_addr == 5'(r)) & (cnt_q[r] == CNT_W'(1)));
`else
      pend[r] = (cnt_q[r] != '0);
`endif
      busy = busy | (cnt_q[r] != '0);
    end
  end

  always_comb begin
    haz1  = i_id_valid & i_rs1_used & (i_rs1_addr != 5'd0) & pend[i_rs1_addr];
    haz2  = i_id_valid & i_rs2_used & (i_rs2_addr != 5'd0) & pend[i_rs2_addr];
    sat   = i_id_valid & i_rd_wren & (i_rd_addr != 5'd0) & (cnt_q[i_rd_addr] == CNT_MAX);
    stall = ~i_reset & (haz1 | haz2 | sat);
    inc   = i_id_valid & ~stall & i_rd_wren & (i_rd_addr != 5'd0);
  end

  // Net arithmetic per register so coincident issue/WB/kill combine in one cycle.
  always_comb begin
    err_d    = err_q;
    net      = '0;
    cnt_d[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      net = {2'b00, cnt_q[r]};
      if (inc && (i_rd_addr == 5'(r)))         net = net + ONE_S;
      if (dec_wb && (i_wb_rd_addr == 5'(r)))   net = net - ONE_S;
      if (dec_kill && (i_kill_rd == 5'(r)))    net = net - ONE_S;
      if (net < 0) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else if (net > MAX_S) begin
        cnt_d[r] = CNT_MAX;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = net[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end

  assign o_stall      = stall;
  assign o_rs1_hazard = haz1;
  assign o_rs2_hazard = haz2;
  assign o_busy_any   = busy;
  assign o_err        = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: the driver queues hand-computed outputs, a monitor checks them.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, rs1_used, rs2_used, rd_wren, kill_valid, wb_wren;
  logic [4:0] rs1, rs2, rd, kill_rd, wb_rd;
  logic       stall, h1, h2, busy, err;

  typedef struct packed {
    int         tag;
    logic [4:0] v;   // {stall, rs1_hazard, rs2_hazard, busy_any, err}
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam logic [4:0] WB_CYCLE_EXP = 5'b00010;
`else
  localparam logic [4:0] WB_CYCLE_EXP = 5'b11010;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_id_valid   (id_valid),
    .i_rs1_addr   (rs1),
    .i_rs2_addr   (rs2),
    .i_rs1_used   (rs1_used),
    .i_rs2_used   (rs2_used),
    .i_rd_addr    (rd),
    .i_rd_wren    (rd_wren),
    .i_kill_valid (kill_valid),
    .i_kill_rd    (kill_rd),
    .i_wb_wren    (wb_wren),
    .i_wb_rd_addr (wb_rd),
    .o_stall      (stall),
    .o_rs1_hazard (h1),
    .o_rs2_hazard (h2),
    .o_busy_any   (busy),
    .o_err        (err)
  );

  function automatic string fname(input int b);
    case (b)
      4:       return "stall";
      3:       return "rs1_hazard";
      2:       return "rs2_hazard";
      1:       return "busy_any";
      default: return "err";
    endcase
  endfunction

  // One cycle of stimulus; e is the expected output vector for that cycle.
  task automatic step(input logic r, input logic v,
                      input logic [4:0] a1, input logic u1,
                      input logic [4:0] a2, input logic u2,
                      input logic [4:0] d,  input logic w,
                      input logic kv, input logic [4:0] kr,
                      input logic wv, input logic [4:0] wr,
                      input logic [4:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; id_valid = v;
    rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
    rd = d; rd_wren = w;
    kill_valid = kv; kill_rd = kr;
    wb_wren = wv; wb_rd = wr;
    cyc++;
    x.tag = cyc;
    x.v   = e;
    exp_q.push_back(x);
  endtask

  initial begin : monitor
    exp_t       x;
    logic [4:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        x   = exp_q.pop_front();
        got = {stall, h1, h2, busy, err};
        for (int b = 0; b < 5; b++) begin
          checks++;
          if (got[b] !== x.v[b]) begin
            errors++;
            $display("FAIL cyc%0d %s got=%0b exp=%0b", x.tag, fname(b), got[b], x.v[b]);
          end
        end
      end
    end
  end

  initial begin : driver
    rst = 1'b1; id_valid = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    rd = 0; rd_wren = 0; kill_valid = 0; kill_rd = 0; wb_wren = 0; wb_rd = 0;
    repeat (2) @(posedge clk);

    //    rst v  rs1 u1 rs2 u2 rd  w  kv kr  wv wr   {st,h1,h2,busy,err}
    step(1, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 0,  5'b00000); // reset cycle, stall forced low
    step(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 0,  5'b00000); // idle after reset
    // RAW on x5
    step(0, 1, 0,  0, 0,  0, 5,  1, 0, 0,  0, 0,  5'b00000);
    step(0, 1, 5,  1, 0,  0, 0,  0, 0, 0,  0, 0,  5'b11010);
    step(0, 1, 5,  1, 0,  0, 0,  0, 0, 0,  0, 0,  5'b11010);
    step(0, 1, 5,  1, 0,  0, 0,  0, 0, 0,  1, 5,  WB_CYCLE_EXP);
    step(0, 1, 5,  1, 0,  0, 0,  0, 0, 0,  0, 0,  5'b00000);
    // immediate op ignores rs2
    step(0, 1, 0,  0, 0,  0, 7,  1, 0, 0,  0, 0,  5'b00000);
    step(0, 1, 0,  1, 7,  0, 0,  0, 0, 0,  0, 0,  5'b00010);
    step(0, 1, 0,  1, 7,  1, 0,  0, 0, 0,  0, 0,  5'b10110);
    step(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  1, 7,  5'b00010);
    step(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 0,  5'b00000);
    // x0 is never tracked; x0 WB/kill never flag err
    step(0, 1, 0,  0, 0,  0, 0,  1, 0, 0,  0, 0,  5'b00000);
    step(0, 1, 0,  1, 0,  1, 0,  0, 1, 0,  1, 0,  5'b00000);
    // simultaneous issue/WB/kill on x3 with cnt=2
    step(0, 1, 0,  0, 0,  0, 3,  1, 0, 0,  0, 0,  5'b00000);
    step(0, 1, 0,  0, 0,  0, 3,  1, 0, 0,  0, 0,  5'b00010);
    step(0, 1, 0,  0, 0,  0, 3,  1, 1, 3,  1, 3,  5'b00010);
    step(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  1, 3,  5'b00010);
    step(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  1, 3,  5'b00000); // underflow attempt
    step(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 0,  5'b00001);
    step(0, 1, 3,  1, 0,  0, 0,  0, 0, 0,  0, 0,  5'b00001);
    // saturation on x9
    step(0, 1, 0,  0, 0,  0, 9,  1, 0, 0,  0, 0,  5'b00001);
    step(0, 1, 0,  0, 0,  0, 9,  1, 0, 0,  0, 0,  5'b00011);
    step(0, 1, 0,  0, 0,  0, 9,  1, 0, 0,  0, 0,  5'b00011);
    step(0, 1, 0,  0, 0,  0, 9,  1, 0, 0,  0, 0,  5'b10011);
    step(0, 1, 0,  0, 0,  0, 9,  1, 0, 0,  1, 9,  5'b10011);
    step(0, 1, 0,  0, 0,  0, 9,  1, 0, 0,  0, 0,  5'b00011);
    step(0, 1, 0,  0, 0,  0, 9,  1, 0, 0,  0, 0,  5'b10011);
    // reset mid-operation clears counts and err
    step(1, 1, 0,  0, 0,  0, 9,  1, 0, 0,  0, 0,  5'b00011);
    step(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 0,  5'b00000);
    // kill retires a pending write
    step(0, 1, 0,  0, 0,  0, 12, 1, 0, 0,  0, 0,  5'b00000);
    step(0, 1, 12, 1, 0,  0, 0,  0, 1, 12, 0, 0,  5'b11010);
    step(0, 1, 12, 1, 0,  0, 0,  0, 0, 0,  0, 0,  5'b00000);

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
